decode_exec: RTL
================

# decode_exec

- Control and execute stage that sits directly downstream of the fetch register pair.
- Decodes the 4-bit opcode/operand nibbles that fetch produces, runs a 4-bit accumulator datapath with carry/zero flags, and handles two-byte conditional jumps.
- Drives the program-counter increment/load and fetch-enable strobes, closing the fetch–decode–execute loop of the 4-bit processor.

## Interface
Parameters:
- none; datapath fixed at 4 bits, address at 12 bits.

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- instr  in  4  opcode nibble from the fetch register (upper nibble of the ROM byte).
- oprnd  in  4  operand nibble from the fetch register (lower nibble).
- data_in  in  4  external input bus, sampled by IN.
- pc_en  out  1  program counter increment enable.
- pc_load  out  1  program counter load strobe; counter takes load_addr.
- load_addr  out  12  jump target, {addr_hi, instr, oprnd}.
- fetch_en  out  1  fetch register enable.
- acc  out  4  accumulator.
- flag_c, flag_z  out  1 each  carry flag and zero flag.
- out_data  out  4  output port register.
- halted  out  1  high while in HALT.

## Operation

**State machine**
- States: FETCH, DECODE, EXEC, FETCH2, JUMP, HALT.
- State is one-hot registered.
- pc_en, fetch_en and pc_load are each driven directly from a flop, with no combinational glitches. This is required because the counter treats its load input as an edge.
- FETCH: pc_en=1 and fetch_en=1. The fetch register captures ROM[PC] and PC increments on the same edge. Next state is DECODE.
- DECODE: all strobes 0.
  - Opcodes 0x0–0x9 go to EXEC.
  - Opcodes 0xA–0xE capture addr_hi<=oprnd, then go to FETCH2.
  - Opcode 0xF goes to HALT.
- EXEC: all strobes 0. The opcode is applied to acc, flags and out_data. Next state is FETCH.
- FETCH2: pc_en=1 and fetch_en=1. The second byte lands in instr/oprnd. Next state is JUMP.
- JUMP: pc_en=0. pc_load=1 only if the condition holds. Next state is FETCH.
- HALT: all strobes 0 and halted=1. The block stays here until reset.

**Opcodes** (evaluated in EXEC; flags not listed keep their value)
- 0 NOP: no change.
- 1 LIT: acc<=oprnd; Z.
- 2 IN: acc<=data_in; Z.
- 3 ADD: {C,acc}<=acc+oprnd, computed 5 bits wide; Z from the 4-bit result.
- 4 SUB: {C,acc}<=acc+~oprnd+1. C=1 means no borrow (acc>=oprnd). Z.
- 5 AND, 6 OR, 7 XOR: acc<=acc op oprnd; Z only.
- 8 CMP: C and Z as for SUB; acc unchanged.
- 9 OUT: out_data<=acc.
- A JMP: always taken.
- B JC: taken if C=1.
- C JNC: taken if C=0.
- D JZ: taken if Z=1.
- E JNZ: taken if Z=0.
- F HALT.

**Jumps**
- Flags are sampled in the JUMP state.
- A jump does not modify acc or the flags.
- Z is always computed from the 4-bit result (result==0).

## Timing
**Reset**
- Asynchronous. State goes to FETCH.
- acc, out_data and addr_hi reset to 0; flags reset to 0.
- The FETCH-state strobe flops reset to 1: pc_en=1 and fetch_en=1 from reset. All other strobes are 0.
- The first fetch edge is the first Clk rise after reset deasserts.

**Instruction latency**
- One-byte instructions take 3 cycles: FETCH, DECODE, EXEC.
- Jumps take 4 cycles: FETCH, DECODE, FETCH2, JUMP, whether taken or not.
- acc, flags and out_data update on the edge that ends EXEC.

**Jump behaviour**
- Taken: the counter holds load_addr after the edge that ends JUMP. The next FETCH reads ROM[load_addr].
- Not taken: PC already points past byte 2, so execution continues sequentially.
- pc_en and pc_load are never high in the same cycle.

**Boundary conditions**
- Address wrap 0xFFF→0x000 is handled by the counter; this block does not treat it specially.
- A HALT encountered as the second byte of a jump is data, not a halt.
- Reset asserted mid-instruction discards the instruction with no partial update. Reset asserted during a pc_load cycle drops pc_load immediately.

## Test plan
1. **Reset:** reset pulse → pc_en=1, fetch_en=1, pc_load=0, acc=0, flags=0, out_data=0, halted=0. The first DECODE occurs one cycle after reset release.
2. **Add with carry:** bytes 0x1C, 0x35 (LIT 12, ADD 5) → acc=0x1, C=1, Z=0 three cycles after the ADD fetch. OUT (0x90) → out_data=0x1.
3. **Compare:** LIT 7, CMP 7 → Z=1, C=1, acc stays 7. CMP 9 → Z=0, C=0.
4. **Jump taken:** JZ with Z=1, bytes 0xD3, 0x4A → pc_load=1 for exactly one cycle in JUMP, load_addr=0x34A, pc_en=0 in that cycle.
5. **Jump not taken:** JNZ with Z=1 → pc_load stays 0, pc_en pulses twice (FETCH, FETCH2), sequential fetch continues.
6. **Halt and mid-instruction reset:** HALT (0xF0) → halted=1, all strobes 0 indefinitely. Reset asserted during EXEC of ADD → acc=0, state FETCH, no ADD result visible.

Source files
------------

// File: rtl/decode_exec.sv
// decode_exec: control/execute stage of the 4-bit processor.
// Decodes the opcode and operand nibbles held by the fetch register and runs
// the accumulator datapath with carry and zero flags. It also sequences the
// two-byte conditional jumps. All strobes to the counter and the fetch
// register come straight from flops.
module decode_exec (
  input  logic        Clk,
  input  logic        reset,
  input  logic [3:0]  instr,
  input  logic [3:0]  oprnd,
  input  logic [3:0]  data_in,
  output logic        pc_en,
  output logic        pc_load,
  output logic [11:0] load_addr,
  output logic        fetch_en,
  output logic [3:0]  acc,
  output logic        flag_c,
  output logic        flag_z,
  output logic [3:0]  out_data,
  output logic        halted
);

  typedef enum logic [5:0] {
    S_FETCH  = 6'b000001,
    S_DECODE = 6'b000010,
    S_EXEC   = 6'b000100,
    S_FETCH2 = 6'b001000,
    S_JUMP   = 6'b010000,
    S_HALT   = 6'b100000
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LIT  = 4'h1,
    OP_IN   = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_CMP  = 4'h8,
    OP_OUT  = 4'h9,
    OP_JMP  = 4'hA,
    OP_JC   = 4'hB,
    OP_JNC  = 4'hC,
    OP_JZ   = 4'hD,
    OP_JNZ  = 4'hE,
    OP_HALT = 4'hF
  } op_t;

  state_t     state;
  logic [3:0] addr_hi;
  op_t        jop;
  logic [4:0] add_r;
  logic [4:0] sub_r;
  logic       jump_take;

  // Jump target: high nibble from byte 1, low byte is byte 2 in the fetch register.
  assign load_addr = {addr_hi, instr, oprnd};

  // Five-bit arithmetic results; bit 4 is the carry (no-borrow for subtract).
  always_comb begin
    add_r = {1'b0, acc} + {1'b0, oprnd};
    sub_r = {1'b0, acc} + {1'b0, ~oprnd} + 5'd1;
  end

  // Jump condition for the opcode latched at decode, evaluated against current flags.
  always_comb begin
    jump_take = 1'b0;
    case (jop)
      OP_JMP:  jump_take = 1'b1;
      OP_JC:   jump_take = flag_c;
      OP_JNC:  jump_take = ~flag_c;
      OP_JZ:   jump_take = flag_z;
      OP_JNZ:  jump_take = ~flag_z;
      default: jump_take = 1'b0;
    endcase
  end

  // Sequencer, registered strobes and execute datapath.
  // Strobes are loaded with the values of the state being entered, so each
  // one is a plain flop output. pc_load is set on the way into JUMP; flags
  // cannot change between FETCH2 and JUMP, so this matches sampling in JUMP.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      pc_en    <= 1'b1;
      fetch_en <= 1'b1;
      pc_load  <= 1'b0;
      halted   <= 1'b0;
      acc      <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      out_data <= '0;
      addr_hi  <= '0;
      jop      <= OP_NOP;
    end else begin
      case (state)
        S_FETCH: begin
          state    <= S_DECODE;
          pc_en    <= 1'b0;
          fetch_en <= 1'b0;
        end
        S_DECODE: begin
          if (instr <= 4'h9) begin
            state <= S_EXEC;
          end else if (instr != 4'hF) begin
            state    <= S_FETCH2;
            addr_hi  <= oprnd;
            jop      <= op_t'(instr);
            pc_en    <= 1'b1;
            fetch_en <= 1'b1;
          end else begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_EXEC: begin
          state    <= S_FETCH;
          pc_en    <= 1'b1;
          fetch_en <= 1'b1;
          case (op_t'(instr))
            OP_LIT: begin
              acc    <= oprnd;
              flag_z <= (oprnd == 4'h0);
            end
            OP_IN: begin
              acc    <= data_in;
              flag_z <= (data_in == 4'h0);
            end
            OP_ADD: begin
              acc    <= add_r[3:0];
              flag_c <= add_r[4];
              flag_z <= (add_r[3:0] == 4'h0);
            end
            OP_SUB: begin
              acc    <= sub_r[3:0];
              flag_c <= sub_r[4];
              flag_z <= (sub_r[3:0] == 4'h0);
            end
            OP_AND: begin
              acc    <= acc & oprnd;
              flag_z <= ((acc & oprnd) == 4'h0);
            end
            OP_OR: begin
              acc    <= acc | oprnd;
              flag_z <= ((acc | oprnd) == 4'h0);
            end
            OP_XOR: begin
              acc    <= acc ^ oprnd;
              flag_z <= ((acc ^ oprnd) == 4'h0);
            end
            OP_CMP: begin
              flag_c <= sub_r[4];
              flag_z <= (sub_r[3:0] == 4'h0);
            end
            OP_OUT: out_data <= acc;
            default: ;
          endcase
        end
        S_FETCH2: begin
          state    <= S_JUMP;
          pc_en    <= 1'b0;
          fetch_en <= 1'b0;
          pc_load  <= jump_take;
        end
        S_JUMP: begin
          state    <= S_FETCH;
          pc_load  <= 1'b0;
          pc_en    <= 1'b1;
          fetch_en <= 1'b1;
        end
        S_HALT: begin
          state    <= S_HALT;
          pc_en    <= 1'b0;
          fetch_en <= 1'b0;
          pc_load  <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state    <= S_FETCH;
          pc_en    <= 1'b1;
          fetch_en <= 1'b1;
          pc_load  <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule
